// File: rtl/shot_turn_if.sv
// Keypad, ball-physics and HUD signals of the shot/turn sequencer.
//   inputs to the sequencer : refr_tick, key, key_pulse, ba/bb_moving, ba/bb_pot
//   outputs from sequencer  : aim/shot angle+force, fire, respawn strobes,
//                             player, scores, state, game_over, winner
interface shot_turn_if;
    logic       refr_tick;
    logic [4:0] key;
    logic [4:0] key_pulse;
    logic       ba_moving;
    logic       bb_moving;
    logic       ba_pot;
    logic       bb_pot;
    logic [8:0] aim_angle;
    logic [5:0] aim_force;
    logic [8:0] shot_angle;
    logic [5:0] shot_force;
    logic       fire;
    logic       respawn_ba;
    logic       respawn_bb;
    logic       player;
    logic [3:0] score0;
    logic [3:0] score1;
    logic [1:0] state;
    logic       game_over;
    logic       winner;

    // Environment side: keypad decoder, physics block and HUD.
    modport master (
        output refr_tick, key, key_pulse, ba_moving, bb_moving, ba_pot, bb_pot,
        input  aim_angle, aim_force, shot_angle, shot_force, fire, respawn_ba,
               respawn_bb, player, score0, score1, state, game_over, winner
    );

    // Sequencer side.
    modport slave (
        input  refr_tick, key, key_pulse, ba_moving, bb_moving, ba_pot, bb_pot,
        output aim_angle, aim_force, shot_angle, shot_force, fire, respawn_ba,
               respawn_bb, player, score0, score1, state, game_over, winner
    );
endinterface

// File: rtl/shot_turn_ctrl.sv
// Two-player turn and shot sequencer for the billiard table.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : shot_turn_if.slave -- keypad/physics inputs, HUD/physics outputs
// AIM collects angle/force, fire launches ball A, ROLL waits for rest (or
// timeout), JUDGE scores the shot for one cycle, OVER holds until restart.
module shot_turn_ctrl #(
    parameter int unsigned MAX_FORCE    = 12,
    parameter int unsigned FORCE_RPT    = 6,
    parameter int unsigned ANG_STEP     = 5,
    parameter int unsigned ANG_RPT      = 4,
    parameter int unsigned SETTLE_TICKS = 30,
    parameter int unsigned ROLL_TIMEOUT = 1023,
    parameter int unsigned WIN_SCORE    = 5
) (
    input  logic         clk,
    input  logic         rst,
    shot_turn_if.slave   bus
);

    localparam int unsigned ANG_W = 9;
    localparam int unsigned FRC_W = 6;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned RPT_W = 4;
    localparam int unsigned SCR_W = 4;

    localparam logic [4:0] KEY_CCW    = 5'h11;
    localparam logic [4:0] KEY_CW     = 5'h17;
    localparam logic [4:0] KEY_CHARGE = 5'h14;
    localparam logic [4:0] KEY_FIRE   = 5'h10;

    typedef enum logic [1:0] {
        ST_AIM   = 2'd0,
        ST_ROLL  = 2'd1,
        ST_JUDGE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t             state_q;
    logic [ANG_W-1:0]   aim_angle_q, shot_angle_q;
    logic [FRC_W-1:0]   aim_force_q, shot_force_q;
    logic [RPT_W-1:0]   ang_rpt_q, frc_rpt_q;
    logic [CNT_W-1:0]   roll_cnt_q, rest_cnt_q;
    logic               first_tick_q;
    logic               pa_q, pb_q;
    logic               fire_q, respawn_ba_q, respawn_bb_q;
    logic               player_q, game_over_q, winner_q;
    logic [SCR_W-1:0]   score0_q, score1_q;

    logic [ANG_W-1:0]   ang_plus, ang_minus;
    logic [RPT_W-1:0]   ang_rpt_inc, frc_rpt_inc;
    logic [CNT_W-1:0]   roll_inc, rest_inc;
    logic               at_rest, fire_req, award, win;
    logic [SCR_W-1:0]   score_inc;

    // Wrapped angle steps, repeat/roll counter increments and judge outcome.
    always_comb begin
        ang_plus    = (aim_angle_q >= ANG_W'(360 - ANG_STEP))
                      ? aim_angle_q - ANG_W'(360 - ANG_STEP)
                      : aim_angle_q + ANG_W'(ANG_STEP);
        ang_minus   = (aim_angle_q < ANG_W'(ANG_STEP))
                      ? aim_angle_q + ANG_W'(360 - ANG_STEP)
                      : aim_angle_q - ANG_W'(ANG_STEP);
        ang_rpt_inc = ang_rpt_q + RPT_W'(1);
        frc_rpt_inc = frc_rpt_q + RPT_W'(1);
        roll_inc    = roll_cnt_q + CNT_W'(1);
        rest_inc    = rest_cnt_q + CNT_W'(1);
        // The first tick after fire never counts towards the rest streak.
        at_rest     = !bus.ba_moving && !bus.bb_moving && !first_tick_q;
        fire_req    = (bus.key_pulse == KEY_FIRE) && (aim_force_q != '0);
        award       = pb_q && !pa_q;
        score_inc   = (player_q ? score1_q : score0_q) + SCR_W'(1);
        win         = award && (score_inc == SCR_W'(WIN_SCORE));
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_AIM;
            aim_angle_q  <= '0;
            aim_force_q  <= '0;
            shot_angle_q <= '0;
            shot_force_q <= '0;
            ang_rpt_q    <= '0;
            frc_rpt_q    <= '0;
            roll_cnt_q   <= '0;
            rest_cnt_q   <= '0;
            first_tick_q <= 1'b0;
            pa_q         <= 1'b0;
            pb_q         <= 1'b0;
            fire_q       <= 1'b0;
            respawn_ba_q <= 1'b0;
            respawn_bb_q <= 1'b0;
            player_q     <= 1'b0;
            score0_q     <= '0;
            score1_q     <= '0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            fire_q       <= 1'b0;
            respawn_ba_q <= 1'b0;
            respawn_bb_q <= 1'b0;
            unique case (state_q)
                ST_AIM: begin
                    if (fire_req) begin
                        // Fire wins over a coincident frame tick.
                        shot_angle_q <= aim_angle_q;
                        shot_force_q <= aim_force_q;
                        aim_force_q  <= '0;
                        fire_q       <= 1'b1;
                        pa_q         <= 1'b0;
                        pb_q         <= 1'b0;
                        roll_cnt_q   <= '0;
                        rest_cnt_q   <= '0;
                        first_tick_q <= 1'b1;
                        ang_rpt_q    <= '0;
                        frc_rpt_q    <= '0;
                        state_q      <= ST_ROLL;
                    end else if (bus.refr_tick) begin
                        if (bus.key == KEY_CCW || bus.key == KEY_CW) begin
                            if (ang_rpt_inc == RPT_W'(ANG_RPT)) begin
                                ang_rpt_q   <= '0;
                                aim_angle_q <= (bus.key == KEY_CCW) ? ang_plus : ang_minus;
                            end else begin
                                ang_rpt_q   <= ang_rpt_inc;
                            end
                        end else begin
                            ang_rpt_q <= '0;
                        end
                        if (bus.key == KEY_CHARGE) begin
                            if (frc_rpt_inc == RPT_W'(FORCE_RPT)) begin
                                frc_rpt_q <= '0;
                                if (aim_force_q != FRC_W'(MAX_FORCE)) begin
                                    aim_force_q <= aim_force_q + FRC_W'(1);
                                end
                            end else begin
                                frc_rpt_q <= frc_rpt_inc;
                            end
                        end else begin
                            frc_rpt_q <= '0;
                        end
                    end
                end
                ST_ROLL: begin
                    pa_q <= pa_q | bus.ba_pot;
                    pb_q <= pb_q | bus.bb_pot;
                    if (bus.refr_tick) begin
                        roll_cnt_q   <= roll_inc;
                        rest_cnt_q   <= at_rest ? rest_inc : '0;
                        first_tick_q <= 1'b0;
                        if ((at_rest && rest_inc == CNT_W'(SETTLE_TICKS)) ||
                            roll_inc == CNT_W'(ROLL_TIMEOUT)) begin
                            state_q <= ST_JUDGE;
                        end
                    end
                end
                ST_JUDGE: begin
                    if (award) begin
                        if (player_q) score1_q <= score_inc;
                        else          score0_q <= score_inc;
                        respawn_bb_q <= 1'b1;
                    end else begin
                        // Foul (ball A potted) or empty shot both pass the turn.
                        player_q     <= ~player_q;
                        respawn_ba_q <= pa_q;
                        respawn_bb_q <= pa_q & pb_q;
                    end
                    game_over_q <= win;
                    winner_q    <= win ? player_q : winner_q;
                    state_q     <= win ? ST_OVER : ST_AIM;
                end
                ST_OVER: begin
                    if (bus.key_pulse == KEY_FIRE) begin
                        score0_q     <= '0;
                        score1_q     <= '0;
                        aim_angle_q  <= '0;
                        aim_force_q  <= '0;
                        shot_angle_q <= '0;
                        shot_force_q <= '0;
                        ang_rpt_q    <= '0;
                        frc_rpt_q    <= '0;
                        player_q     <= 1'b0;
                        game_over_q  <= 1'b0;
                        winner_q     <= 1'b0;
                        state_q      <= ST_AIM;
                    end
                end
            endcase
        end
    end

    assign bus.aim_angle  = aim_angle_q;
    assign bus.aim_force  = aim_force_q;
    assign bus.shot_angle = shot_angle_q;
    assign bus.shot_force = shot_force_q;
    assign bus.fire       = fire_q;
    assign bus.respawn_ba = respawn_ba_q;
    assign bus.respawn_bb = respawn_bb_q;
    assign bus.player     = player_q;
    assign bus.score0     = score0_q;
    assign bus.score1     = score1_q;
    assign bus.state      = state_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;

endmodule

// File: doc/shot_turn_ctrl.md
Name: shot_turn_ctrl

Overview:
Two-player turn and shot sequencer for the billiard table. It collects aim angle and charge force from the keypad and launches ball A through a one-shot fire strobe. It waits for both balls to come to rest, then judges pocket events, updates scores and hands over the turn. It sits between the keypad decoder and the ball-physics block, and drives the HUD with aim, score and player outputs.

Parameters:
MAX_FORCE, 12, saturation value of the charge force
FORCE_RPT, 6, refr_ticks per +1 force step while charge key held
ANG_STEP, 5, degrees per angle step
ANG_RPT, 4, refr_ticks per angle step while rotate key held
SETTLE_TICKS, 30, consecutive at-rest refr_ticks needed to end a roll
ROLL_TIMEOUT, 1023, maximum refr_ticks spent in ROLL
WIN_SCORE, 5, score that ends the game

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
refr_tick  in  1  one-cycle 60 Hz frame strobe
key  in  5  held-key code (5'h11 rotate CCW, 5'h17 rotate CW, 5'h14 charge)
key_pulse  in  5  one-cycle key-press code (5'h10 = fire/restart)
ba_moving  in  1  ball A velocity nonzero
bb_moving  in  1  ball B velocity nonzero
ba_pot  in  1  ball A inside a hole (level)
bb_pot  in  1  ball B inside a hole (level)
aim_angle  out  9  live aim angle, 0..355 degrees
aim_force  out  6  live charge force, 0..MAX_FORCE
shot_angle  out  9  angle latched at fire
shot_force  out  6  force latched at fire
fire  out  1  one-cycle launch strobe to physics
respawn_ba  out  1  one-cycle strobe: return ball A to its start point
respawn_bb  out  1  one-cycle strobe: return ball B to its start point
player  out  1  current shooter
score0  out  4  player 0 score
score1  out  4  player 1 score
state  out  2  0 AIM, 1 ROLL, 2 JUDGE, 3 OVER
game_over  out  1  high in OVER
winner  out  1  valid when game_over

Behaviour:
Reset (rst=0, asynchronous):
- State goes to AIM.
- All outputs, counters and pot latches clear to 0; player=0.

AIM:
- Angle, on refr_tick only: while key==5'h11, a repeat counter increments. When it reaches ANG_RPT, the counter clears and aim_angle += ANG_STEP. Wrap: 355+5 → 0.
- key==5'h17 behaves the same with -ANG_STEP. Wrap: 0-5 → 355.
- Any other key value clears the angle repeat counter.
- Force, on refr_tick only: while key==5'h14, a repeat counter counts to FORCE_RPT, then aim_force += 1, saturating at MAX_FORCE. Releasing the key holds aim_force.
- Fire: key_pulse==5'h10 with aim_force>0 does the following in one cycle:
  - shot_angle <= aim_angle; shot_force <= aim_force;
  - fire=1 for exactly that following cycle;
  - aim_force <= 0; aim_angle is kept;
  - clear pot latches and ROLL counters;
  - state → ROLL.
- key_pulse==5'h10 with aim_force==0 is ignored.
- Fire coinciding with refr_tick: fire wins; that tick's angle and force steps are dropped.
- Keys have no effect outside AIM, except the OVER restart.

ROLL:
- Sticky latches pa/pb set whenever ba_pot/bb_pot is high, including the cycle ROLL exits.
- On each refr_tick:
  - roll_cnt++ (10-bit).
  - rest_cnt++ if !ba_moving && !bb_moving, else rest_cnt <= 0.
- Exit to JUDGE on the refr_tick where rest_cnt reaches SETTLE_TICKS, or where roll_cnt reaches ROLL_TIMEOUT.
- The first refr_tick after fire is not counted as rest; rest_cnt starts from 0.

JUDGE (exactly one cycle):
- pb && !pa: current player's score +1, player unchanged, respawn_bb=1.
- pa: foul, player toggles, respawn_ba=1. If pb also set, respawn_bb=1 and no point is awarded.
- Neither set: player toggles.
- Next state is OVER if the updated score == WIN_SCORE, else AIM.
- Respawn strobes are one cycle, coincident with the JUDGE-exit edge.

OVER:
- game_over=1; winner = player holding WIN_SCORE.
- key_pulse==5'h10 clears scores, aim and shot registers, sets player=0, state → AIM.

Widths and reset mid-operation:
- Scores are 4-bit. WIN_SCORE ≤ 15 guarantees no overflow.
- Async reset during any state aborts immediately with no strobe emitted.

Test Plan:
- Reset release, key=5'h11 held for 8 refr_ticks with ANG_RPT=4 → aim_angle=10; key=5'h17 held for 12 refr_ticks from 0 → aim_angle=345.
- key=5'h14 held for 100 refr_ticks → aim_force saturates at 12; key_pulse=5'h10 → fire high 1 cycle, shot_force=12, aim_force=0, state=1.
- In ROLL, balls moving for 50 ticks and then at rest for 30 ticks with bb_pot pulsed once → JUDGE: score0=1, player=0, respawn_bb 1 cycle, back to AIM.
- ba_pot and bb_pot both pulsed during ROLL → player toggles to 1, scores unchanged, respawn_ba and respawn_bb both pulse.
- ba_moving stuck high → exit ROLL after 1023 refr_ticks, player toggles.
- Player 0 reaches score 5 → state=3, game_over=1, winner=0; key_pulse=5'h10 → scores 0, state=0. Additionally, rst=0 asserted mid-ROLL → state=0, all outputs 0 asynchronously.
